mul_operand_packer: RTL and testbench

//  Issue-side front end of the bf16 multiplier tree. Takes one bf16 operand per cycle from
//  a valid/ready stream, groups operands into product nodes by fan-in mode, and packs nodes

---
 rtl/mul_operand_packer.sv | 180 ++++++++++++++++++
 tb/tb_mul_operand_packer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_operand_packer.sv
// Issue-side front end of the bf16 multiplier tree: groups a valid/ready operand stream into
// product nodes and 8-slot batches. Defining PACKER_TIMEOUT_EN adds an idle auto-flush.
module mul_operand_packer #(
  parameter int                DATA_W         = 16,
  parameter logic [DATA_W-1:0] ONE_VAL        = 16'h3F80,
  parameter int                DRAIN_CYCLES   = 7,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_last,
  input  logic [1:0]          s_mode,
  input  logic                flush,
  output logic [8*DATA_W-1:0] mul_ins,
  output logic                mul_stb,
  output logic [1:0]          mode,
  output logic [2:0]          batch_nodes,
  output logic                err_fanin
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LD = DW'(DRAIN_CYCLES);

  function automatic logic [2:0] cap_of(input logic [1:0] m);
    case (m)
      2'd0:    cap_of = 3'd2;
      2'd1:    cap_of = 3'd3;
      2'd2:    cap_of = 3'd4;
      default: cap_of = 3'd6;
    endcase
  endfunction

  function automatic logic [2:0] npb_of(input logic [1:0] m);
    case (m)
      2'd0:    npb_of = 3'd4;
      2'd1:    npb_of = 3'd2;
      2'd2:    npb_of = 3'd2;
      default: npb_of = 3'd1;
    endcase
  endfunction

  // First slot of node n; 3-in nodes sit on the same 4-slot stride as 4-in nodes
  function automatic logic [2:0] base_of(input logic [1:0] m, input logic [2:0] n);
    case (m)
      2'd0:    base_of = {n[1:0], 1'b0};
      2'd1:    base_of = {n[0], 2'b00};
      2'd2:    base_of = {n[0], 2'b00};
      default: base_of = 3'd0;
    endcase
  endfunction

  logic [8*DATA_W-1:0] stage_r, mul_ins_r, nxt_stage_s;
  logic [2:0]          nodes_r, beat_r, nxt_nodes_s, nxt_beat_s, beat_inc_s;
  logic [2:0]          cap_s, slot_s, issue_nodes_s, batch_nodes_r;
  logic [1:0]          stage_mode_r, mode_r, nxt_mode_s, ref_mode_s, eff_mode_s;
  logic [DW-1:0]       drain_r;
  logic                mul_stb_r, err_r, err_s, complete_s;
  logic                first_s, nonempty_s, nxt_nonempty_s, mode_diff_s, drain_ok_s;
  logic                s_ready_s, acc_s, chg_issue_s, timeout_s, issue_s;

  assign first_s     = (beat_r == 3'd0);
  assign nonempty_s  = (nodes_r != 3'd0) || (beat_r != 3'd0);
  assign ref_mode_s  = nonempty_s ? stage_mode_r : mode_r;
  assign mode_diff_s = first_s && (s_mode != ref_mode_s);
  assign drain_ok_s  = (drain_r == {DW{1'b0}}) && !mul_stb_r;
  // A mode change must first issue any partial batch, then wait out the tree drain
  assign s_ready_s   = !rst && !(mode_diff_s && (nonempty_s || !drain_ok_s));
  assign acc_s       = s_valid && s_ready_s;
  assign chg_issue_s = !rst && s_valid && mode_diff_s && nonempty_s;
  assign eff_mode_s  = first_s ? s_mode : stage_mode_r;

  // Next staging contents after this cycle's accepted beat
  always_comb begin
    nxt_nodes_s = nodes_r;
    nxt_beat_s  = beat_r;
    nxt_mode_s  = stage_mode_r;
    err_s       = 1'b0;
    complete_s  = 1'b0;
    beat_inc_s  = beat_r + 3'd1;
    cap_s       = cap_of(eff_mode_s);
    slot_s      = base_of(eff_mode_s, nodes_r) + beat_r;
    nxt_stage_s = stage_r;
    for (int k = 0; k < 8; k++) begin
      nxt_stage_s[k*DATA_W +: DATA_W] = (acc_s && (slot_s == 3'(k))) ? s_data
                                                                      : stage_r[k*DATA_W +: DATA_W];
    end
    if (acc_s) begin
      nxt_mode_s = eff_mode_s;
      if (s_last || (beat_inc_s == cap_s)) begin
        nxt_nodes_s = nodes_r + 3'd1;
        nxt_beat_s  = 3'd0;
        err_s       = ~s_last;
        complete_s  = ((nodes_r + 3'd1) == npb_of(eff_mode_s));
      end else begin
        nxt_beat_s = beat_inc_s;
      end
    end else begin
      nxt_mode_s = stage_mode_r;
    end
  end

  assign nxt_nonempty_s = (nxt_nodes_s != 3'd0) || (nxt_beat_s != 3'd0);
  assign issue_nodes_s  = nxt_nodes_s + {2'b00, (nxt_beat_s != 3'd0)};
  assign issue_s        = !rst && (complete_s || chg_issue_s
                                   || ((flush || timeout_s) && nxt_nonempty_s));

`ifdef PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_r;

  assign timeout_s = nonempty_s && !acc_s && (idle_r == TW'(TIMEOUT_CYCLES - 1));

  // Counts consecutive cycles a partial batch sits without an accept
  always_ff @(posedge clk) begin
    if (rst || acc_s || issue_s || !nonempty_s) begin
      idle_r <= {TW{1'b0}};
    end else begin
      idle_r <= idle_r + TW'(1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Staging, issue registers and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r       <= {8{ONE_VAL}};
      nodes_r       <= 3'd0;
      beat_r        <= 3'd0;
      stage_mode_r  <= 2'd0;
      mul_ins_r     <= {(8*DATA_W){1'b0}};
      mul_stb_r     <= 1'b0;
      mode_r        <= 2'd0;
      batch_nodes_r <= 3'd0;
      err_r         <= 1'b0;
    end else begin
      mul_stb_r <= issue_s;
      err_r     <= err_s;
      if (issue_s) begin
        mul_ins_r     <= nxt_stage_s;
        mode_r        <= nxt_mode_s;
        batch_nodes_r <= issue_nodes_s;
        stage_r       <= {8{ONE_VAL}};
        nodes_r       <= 3'd0;
        beat_r        <= 3'd0;
        stage_mode_r  <= nxt_mode_s;
      end else begin
        stage_r      <= nxt_stage_s;
        nodes_r      <= nxt_nodes_s;
        beat_r       <= nxt_beat_s;
        stage_mode_r <= nxt_mode_s;
      end
    end
  end

  // Drain counter: reloads during each strobe, then counts down to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_r <= {DW{1'b0}};
    end else if (mul_stb_r) begin
      drain_r <= DRAIN_LD;
    end else if (drain_r != {DW{1'b0}}) begin
      drain_r <= drain_r - DW'(1);
    end else begin
      drain_r <= drain_r;
    end
  end

  assign s_ready     = s_ready_s;
  assign mul_ins     = mul_ins_r;
  assign mul_stb     = mul_stb_r;
  assign mode        = mode_r;
  assign batch_nodes = batch_nodes_r;
  assign err_fanin   = err_r;

endmodule

// File: tb/tb_mul_operand_packer.sv
// Self-checking bench for mul_operand_packer: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_mul_operand_packer;

  logic         clk = 1'b0;
  logic         rst, s_valid, s_ready, s_last, flush, mul_stb, err_fanin;
  logic [15:0]  s_data;
  logic [1:0]   s_mode, mode;
  logic [127:0] mul_ins;
  logic [2:0]   batch_nodes;
  logic         rdy_seen;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  mul_operand_packer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .s_mode(s_mode), .flush(flush), .mul_ins(mul_ins), .mul_stb(mul_stb),
    .mode(mode), .batch_nodes(batch_nodes), .err_fanin(err_fanin)
  );

  function automatic logic [15:0] slot(input int k);
    return mul_ins[k*16 +: 16];
  endfunction

  // One clock: s_ready sampled mid-cycle, registered outputs read 1 time unit after the edge
  task automatic drive(input logic v, input logic [15:0] d, input logic l,
                       input logic [1:0] m, input logic f);
    s_valid = v; s_data = d; s_last = l; s_mode = m; flush = f;
    @(negedge clk);
    rdy_seen = s_ready;
    @(posedge clk);
    #1;
    s_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic l, input logic [1:0] m, output int stalls);
    stalls = 0;
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, d, l, m, 1'b0);
      if (rdy_seen) break;
      stalls++;
    end
    total++;
    if (!rdy_seen) begin bad++; $display("FAIL send_timeout data=%h stalls=%0d", d, stalls); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 16'h1234, 1'b0, 2'd0, 1'b1);
    drive(1'b1, 16'h1234, 1'b0, 2'd0, 1'b1);
    total++; if (rdy_seen !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", rdy_seen); end
    total++;
    if ({mul_ins, mul_stb, mode, batch_nodes, err_fanin} !== 135'd0) begin
      bad++; $display("FAIL rst_outputs got stb=%b mode=%0d bn=%0d err=%b ins=%h exp all 0",
                      mul_stb, mode, batch_nodes, err_fanin, mul_ins);
    end
    rst = 1'b0;
  endtask

  task automatic test_mode0_fill();
    int st; logic [15:0] ev;
    for (int i = 0; i < 8; i++) begin
      ev = 16'h4000 + 16'(i);
      send(ev, (i % 2) == 1, 2'd0, st);
      total++; if (st != 0) begin bad++; $display("FAIL m0_ready beat=%0d stalls=%0d exp=0", i, st); end
      if (i < 7) begin
        total++; if (mul_stb !== 1'b0) begin bad++; $display("FAIL m0_early_stb beat=%0d got=1 exp=0", i); end
      end
    end
    total++; if (mul_stb !== 1'b1) begin bad++; $display("FAIL m0_stb got=%b exp=1", mul_stb); end
    for (int k = 0; k < 8; k++) begin
      ev = 16'h4000 + 16'(k);
      total++; if (slot(k) !== ev) begin bad++; $display("FAIL m0_slot%0d got=%h exp=%h", k, slot(k), ev); end
    end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL m0_mode got=%0d exp=0", mode); end
    total++; if (batch_nodes !== 3'd4) begin bad++; $display("FAIL m0_nodes got=%0d exp=4", batch_nodes); end
    drive(1'b0, 16'h0000, 1'b0, 2'd0, 1'b0);
    total++; if (mul_stb !== 1'b0) begin bad++; $display("FAIL m0_stb_pulse got=%b exp=0", mul_stb); end
    total++; if (slot(7) !== 16'h4007) begin bad++; $display("FAIL m0_hold got=%h exp=4007", slot(7)); end
  endtask

  task automatic test_mode1_pad();
    int st;
    logic [15:0] exp_s [8];
    exp_s = '{16'h4000, 16'h4040, 16'h3F80, 16'h3F80, 16'h4080, 16'h40A0, 16'h40C0, 16'h3F80};
    send(16'h4000, 1'b0, 2'd1, st);
    send(16'h4040, 1'b1, 2'd1, st);
    send(16'h4080, 1'b0, 2'd1, st);
    send(16'h40A0, 1'b0, 2'd1, st);
    send(16'h40C0, 1'b1, 2'd1, st);
    total++; if (mul_stb !== 1'b1) begin bad++; $display("FAIL m1_stb got=%b exp=1", mul_stb); end
    for (int k = 0; k < 8; k++) begin
      total++; if (slot(k) !== exp_s[k]) begin bad++; $display("FAIL m1_slot%0d got=%h exp=%h", k, slot(k), exp_s[k]); end
    end
    total++; if (batch_nodes !== 3'd2) begin bad++; $display("FAIL m1_nodes got=%0d exp=2", batch_nodes); end
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL m1_mode got=%0d exp=1", mode); end
  endtask

  task automatic test_mode_switch_drain();
    int st; logic [15:0] ev;
    for (int i = 0; i < 8; i++) send(16'h4000 + 16'(i), (i % 2) == 1, 2'd0, st);
    total++; if (mul_stb !== 1'b1) begin bad++; $display("FAIL sw_first_stb got=%b exp=1", mul_stb); end
    drive(1'b0, 16'h0000, 1'b0, 2'd0, 1'b0);
    send(16'h4100, 1'b0, 2'd3, st);
    total++; if (st != 7) begin bad++; $display("FAIL sw_drain_stalls got=%0d exp=7", st); end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL sw_mode_early got=%0d exp=0", mode); end
    for (int i = 1; i < 6; i++) begin
      send(16'h4100 + 16'(i), i == 5, 2'd3, st);
      total++; if (st != 0) begin bad++; $display("FAIL sw_same_mode_stall beat=%0d got=%0d exp=0", i, st); end
    end
    total++; if (mul_stb !== 1'b1) begin bad++; $display("FAIL sw_stb got=%b exp=1", mul_stb); end
    total++; if (mode !== 2'd3) begin bad++; $display("FAIL sw_mode got=%0d exp=3", mode); end
    for (int k = 0; k < 8; k++) begin
      ev = (k < 6) ? 16'h4100 + 16'(k) : 16'h3F80;
      total++; if (slot(k) !== ev) begin bad++; $display("FAIL sw_slot%0d got=%h exp=%h", k, slot(k), ev); end
    end
    total++; if (batch_nodes !== 3'd1) begin bad++; $display("FAIL sw_nodes got=%0d exp=1", batch_nodes); end
  endtask

  task automatic test_flush();
    int st; logic [15:0] ev;
    send(16'h4200, 1'b0, 2'd0, st);
    send(16'h4201, 1'b1, 2'd0, st);
    send(16'h4202, 1'b0, 2'd0, st);
    total++; if (mul_stb !== 1'b0) begin bad++; $display("FAIL fl_pre_stb got=1 exp=0"); end
    drive(1'b0, 16'h0000, 1'b0, 2'd0, 1'b1);
    total++; if (mul_stb !== 1'b1) begin bad++; $display("FAIL fl_stb got=%b exp=1", mul_stb); end
    for (int k = 0; k < 8; k++) begin
      ev = (k < 3) ? 16'h4200 + 16'(k) : 16'h3F80;
      total++; if (slot(k) !== ev) begin bad++; $display("FAIL fl_slot%0d got=%h exp=%h", k, slot(k), ev); end
    end
    total++; if (batch_nodes !== 3'd2) begin bad++; $display("FAIL fl_nodes got=%0d exp=2", batch_nodes); end
    drive(1'b0, 16'h0000, 1'b0, 2'd0, 1'b1);
    total++; if (mul_stb !== 1'b0) begin bad++; $display("FAIL fl_empty_ignored got=1 exp=0"); end
    drive(1'b1, 16'h4210, 1'b0, 2'd0, 1'b1);
    total++; if (rdy_seen !== 1'b1) begin bad++; $display("FAIL fl_beat_ready got=%b exp=1", rdy_seen); end
    total++; if ({mul_stb, batch_nodes, slot(0), slot(1)} !== {1'b1, 3'd1, 16'h4210, 16'h3F80}) begin
      bad++; $display("FAIL fl_with_beat got stb=%b bn=%0d s0=%h s1=%h exp 1/1/4210/3f80",
                      mul_stb, batch_nodes, slot(0), slot(1));
    end
  endtask

  task automatic test_err_fanin();
    int st; logic [15:0] ev;
    for (int i = 0; i < 5; i++) begin
      send(16'h4300 + 16'(i), 1'b0, 2'd2, st);
      total++;
      if (err_fanin !== (i == 3)) begin bad++; $display("FAIL err_pulse beat=%0d got=%b exp=%b", i, err_fanin, i == 3); end
    end
    drive(1'b0, 16'h0000, 1'b0, 2'd2, 1'b1);
    for (int k = 0; k < 8; k++) begin
      ev = (k < 5) ? 16'h4300 + 16'(k) : 16'h3F80;
      total++; if (slot(k) !== ev) begin bad++; $display("FAIL err_slot%0d got=%h exp=%h", k, slot(k), ev); end
    end
    total++; if ({mul_stb, batch_nodes, mode} !== {1'b1, 3'd2, 2'd2}) begin
      bad++; $display("FAIL err_issue got stb=%b bn=%0d mode=%0d exp 1/2/2", mul_stb, batch_nodes, mode);
    end
    send(16'h4310, 1'b0, 2'd2, st);
    send(16'h4311, 1'b0, 2'd2, st);
    rst = 1'b1;
    drive(1'b1, 16'h4312, 1'b0, 2'd2, 1'b0);
    total++; if (rdy_seen !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", rdy_seen); end
    total++; if ({mul_ins, mul_stb, mode, batch_nodes, err_fanin} !== 135'd0) begin
      bad++; $display("FAIL midrst_outputs got stb=%b mode=%0d bn=%0d ins=%h exp all 0", mul_stb, mode, batch_nodes, mul_ins);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 16'h0000, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 2'd0, 1'b1);
    total++; if (mul_stb !== 1'b0) begin bad++; $display("FAIL midrst_discard got stb=1 exp=0"); end
  endtask

  task automatic test_timeout();
    int st; int hit;
    hit = -1;
    send(16'h4400, 1'b0, 2'd0, st);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 16'h0000, 1'b0, 2'd0, 1'b0);
      if (mul_stb === 1'b1 && hit < 0) hit = i;
    end
`ifdef PACKER_TIMEOUT_EN
    total++; if (hit != 16) begin bad++; $display("FAIL timeout_at got=%0d exp=16", hit); end
    total++; if (batch_nodes !== 3'd1) begin bad++; $display("FAIL timeout_nodes got=%0d exp=1", batch_nodes); end
`else
    total++; if (hit != -1) begin bad++; $display("FAIL no_timeout got stb at idle %0d exp none", hit); end
    drive(1'b0, 16'h0000, 1'b0, 2'd0, 1'b1);
    total++; if ({mul_stb, batch_nodes, slot(0)} !== {1'b1, 3'd1, 16'h4400}) begin
      bad++; $display("FAIL late_flush got stb=%b bn=%0d s0=%h exp 1/1/4400", mul_stb, batch_nodes, slot(0));
    end
`endif
  endtask

  // Randomized run against a model holding staged operands and node lengths in queues
  task automatic test_random();
    logic [15:0] ops[$];
    int lens[$];
    int open_len, last_stb, last_act, cyc, cap, npb, stride, idx, nn;
    logic [1:0] m_mode, out_mode, pref, m;
    logic [127:0] e_ins;
    logic [2:0] e_nodes;
    logic e_stb, e_err, e_rdy, v, l, f, first, nonempty, diff, acc, issue;
    logic [15:0] d;
    do_reset();
    open_len = 0; last_stb = -100; last_act = 0; cyc = 0;
    m_mode = 2'd0; out_mode = 2'd0; pref = 2'd0;
    e_ins = 128'd0; e_nodes = 3'd0;
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(0, 99) < 70);
      d = 16'($urandom);
      l = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 29) == 0) pref = 2'($urandom);
      m = ($urandom_range(0, 9) == 0) ? 2'($urandom) : pref;
      f = ($urandom_range(0, 24) == 0);
      first = (open_len == 0);
      nonempty = (ops.size() > 0);
      diff = first && (m != (nonempty ? m_mode : out_mode));
      e_rdy = !diff || (!nonempty && cyc >= last_stb + 8);
      acc = v && e_rdy;
      issue = v && diff && nonempty;
      e_err = 1'b0;
      if (acc) begin
        if (first) m_mode = m;
        ops.push_back(d);
        open_len++;
        cap = (m_mode == 2'd0) ? 2 : (m_mode == 2'd1) ? 3 : (m_mode == 2'd2) ? 4 : 6;
        npb = (m_mode == 2'd0) ? 4 : (m_mode == 2'd3) ? 1 : 2;
        if (l || open_len == cap) begin
          e_err = !l;
          lens.push_back(open_len);
          open_len = 0;
          if (lens.size() == npb) issue = 1'b1;
        end
        last_act = cyc;
      end
      if (f && ops.size() > 0) issue = 1'b1;
`ifdef PACKER_TIMEOUT_EN
      if (!acc && ops.size() > 0 && (cyc - last_act) >= 16) issue = 1'b1;
`endif
      drive(v, d, l, m, f);
      total++; if (rdy_seen !== e_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, rdy_seen, e_rdy); end
      if (issue) begin
        stride = (m_mode == 2'd0) ? 2 : (m_mode == 2'd3) ? 0 : 4;
        e_ins = {8{16'h3F80}};
        idx = 0;
        if (open_len > 0) lens.push_back(open_len);
        nn = lens.size();
        for (int n = 0; n < nn; n++) begin
          for (int j = 0; j < lens[n]; j++) begin
            e_ins[(n*stride + j)*16 +: 16] = ops[idx];
            idx++;
          end
        end
        e_nodes = 3'(nn);
        out_mode = m_mode;
        last_stb = cyc + 1;
        ops.delete(); lens.delete(); open_len = 0; last_act = cyc;
      end
      e_stb = issue;
      total++;
      if ({mul_stb, err_fanin, mode, batch_nodes} !== {e_stb, e_err, out_mode, e_nodes}) begin
        bad++; $display("FAIL rnd_ctrl cyc=%0d got stb=%b err=%b mode=%0d bn=%0d exp %b/%b/%0d/%0d",
                        cyc, mul_stb, err_fanin, mode, batch_nodes, e_stb, e_err, out_mode, e_nodes);
      end
      total++; if (mul_ins !== e_ins) begin bad++; $display("FAIL rnd_ins cyc=%0d got=%h exp=%h", cyc, mul_ins, e_ins); end
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 16'h0000; s_last = 1'b0; s_mode = 2'd0; flush = 1'b0;
    test_reset();
    test_mode0_fill();
    test_mode1_pad();
    test_mode_switch_drain();
    test_flush();
    test_err_fanin();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
